whac_a_mole_game_fsm: RTL and testbench

- Central game controller for the Whac-A-Mole FPGA game.
- Sequences start, mole arming, hit/miss detection and scoring.
- Sits between the RNG/LED driver, the response timer and the user switches/keys.
- Outputs the score and the decoded difficulty level.

---
 rtl/whac_a_mole_game_fsm_if.sv | 30 +++
 rtl/whac_a_mole_game_fsm.sv | 134 +++++++++++++
 tb/tb_whac_a_mole_game_fsm.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/whac_a_mole_game_fsm_if.sv
// Signal bundle between the Whac-A-Mole game controller and its surroundings
// (RNG/LED driver, response timer, user switches and keys).
interface whac_a_mole_game_fsm_if #(
    parameter int POINTS_W = 16
);
    logic                start_button_pressed;
    logic                timeout;
    logic                reset_button_pressed;
    logic                rng_ready;
    logic [17:0]         toggle_switches;
    logic [3:0]          key_switches;
    logic [17:0]         led_number;
    logic [2:0]          level_select;
    logic                ledx;
    logic                ready_for_mole;
    logic                timeout_start;
    logic [POINTS_W-1:0] points;

    modport master (
        output start_button_pressed, timeout, reset_button_pressed, rng_ready,
               toggle_switches, key_switches, led_number,
        input  level_select, ledx, ready_for_mole, timeout_start, points
    );

    modport slave (
        input  start_button_pressed, timeout, reset_button_pressed, rng_ready,
               toggle_switches, key_switches, led_number,
        output level_select, ledx, ready_for_mole, timeout_start, points
    );
endinterface

// File: rtl/whac_a_mole_game_fsm.sv
// Whac-A-Mole game controller: sequences start, mole arming, hit/miss
// detection and streak-weighted scoring; decodes the difficulty level keys.
module whac_a_mole_game_fsm #(
    parameter int POINTS_W    = 16,
    parameter int STREAK_W    = 8,
    parameter int BASE_POINTS = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    whac_a_mole_game_fsm_if.slave  game
);
    typedef enum logic [2:0] {
        S0_IDLE          = 3'd0,
        S1_CHOOSE_MOLE   = 3'd1,
        S2_WAIT_FOR_HIT  = 3'd2,
        S3_HIT           = 3'd3,
        S4_MISS          = 3'd4
    } state_t;

    localparam int MULT_W = STREAK_W + 3;
    localparam int SUM_W  = POINTS_W + MULT_W + 16;
    localparam logic [POINTS_W-1:0] POINTS_MAX = '1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

    state_t                current_state;
    logic [POINTS_W-1:0]   points_reg;
    logic [POINTS_W-1:0]   points_next;
    logic [STREAK_W-1:0]   streak_reg;
    logic [STREAK_W-1:0]   streak_next;
    logic [STREAK_W-1:0]   streak_div;
    logic [2:0]            level_select;
    logic [2:0]            level_base;
    logic [MULT_W-1:0]     multiplier;
    logic [SUM_W-1:0]      points_sum;
    logic [17:0]           hit_bits;
    logic                  switchx;

    always_comb begin
        level_select = 3'b000;
        case (game.key_switches)
            4'b0001: level_select = 3'b000;
            4'b0010: level_select = 3'b001;
            4'b0100: level_select = 3'b010;
            4'b1000: level_select = 3'b100;
            default: level_select = 3'b000;
        endcase
    end

    always_comb begin
        level_base = 3'd0;
        case (level_select)
            3'b001:  level_base = 3'd1;
            3'b010:  level_base = 3'd3;
            3'b100:  level_base = 3'd5;
            default: level_base = 3'd0;
        endcase
    end

    // A hit is any lit mole whose matching toggle switch is up.
    for (genvar gi = 0; gi < 18; gi++) begin : g_hit
        assign hit_bits[gi] = game.toggle_switches[gi] & game.led_number[gi];
    end
    assign switchx = |hit_bits;

    // Bonus only kicks in once five hits in a row have been landed.
    assign streak_div  = streak_reg / STREAK_W'(5);
    assign multiplier  = (streak_reg < STREAK_W'(5)) ? MULT_W'(1)
                       : MULT_W'(level_base) + MULT_W'(streak_div);
    assign points_sum  = SUM_W'(points_reg) + SUM_W'(BASE_POINTS) * SUM_W'(multiplier);
    assign points_next = (points_sum > SUM_W'(POINTS_MAX)) ? POINTS_MAX
                       : points_sum[POINTS_W-1:0];
    assign streak_next = (streak_reg == STREAK_MAX) ? streak_reg : streak_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state <= S0_IDLE;
            points_reg    <= '0;
            streak_reg    <= '0;
        end else begin
            case (current_state)
                S0_IDLE: begin
                    points_reg <= '0;
                    streak_reg <= '0;
                    if (game.start_button_pressed)
                        current_state <= S1_CHOOSE_MOLE;
                end
                S1_CHOOSE_MOLE: begin
                    if (game.reset_button_pressed) begin
                        current_state <= S0_IDLE;
                        points_reg    <= '0;
                        streak_reg    <= '0;
                    end else if (game.rng_ready) begin
                        current_state <= S2_WAIT_FOR_HIT;
                    end
                end
                S2_WAIT_FOR_HIT: begin
                    // A hit landing on the same cycle the window closes still counts.
                    if (game.reset_button_pressed) begin
                        current_state <= S0_IDLE;
                        points_reg    <= '0;
                        streak_reg    <= '0;
                    end else if (switchx) begin
                        current_state <= S3_HIT;
                        points_reg    <= points_next;
                        streak_reg    <= streak_next;
                    end else if (!game.timeout) begin
                        current_state <= S4_MISS;
                        streak_reg    <= '0;
                    end
                end
                S3_HIT, S4_MISS: begin
                    if (game.reset_button_pressed) begin
                        current_state <= S0_IDLE;
                        points_reg    <= '0;
                        streak_reg    <= '0;
                    end else begin
                        current_state <= S1_CHOOSE_MOLE;
                    end
                end
                default: begin
                    current_state <= S0_IDLE;
                    points_reg    <= '0;
                    streak_reg    <= '0;
                end
            endcase
        end
    end

    assign game.ready_for_mole = (current_state == S1_CHOOSE_MOLE);
    assign game.ledx           = (current_state == S2_WAIT_FOR_HIT);
    assign game.timeout_start  = (current_state == S2_WAIT_FOR_HIT);
    assign game.level_select   = level_select;
    assign game.points         = points_reg;
endmodule

// File: tb/tb_whac_a_mole_game_fsm.sv
// Scoreboard bench for the Whac-A-Mole controller: a driver feeds directed and
// random cycles through a rule-level game model, a monitor compares each cycle.
module tb_whac_a_mole_game_fsm;
    localparam int POINTS_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    whac_a_mole_game_fsm_if #(.POINTS_W(POINTS_W)) ifc();

    whac_a_mole_game_fsm #(
        .POINTS_W   (POINTS_W),
        .STREAK_W   (8),
        .BASE_POINTS(10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .game (ifc)
    );

    typedef struct {
        int id;
        int state;
        int ready;
        int ledx;
        int points;
        int level;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    // Game model: phase 0 idle, 1 choosing, 2 waiting, 3 hit, 4 miss.
    int m_state = 0;
    int m_points = 0;
    int m_streak = 0;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, expv);
        end
    endtask

    function automatic int decode_level(input logic [3:0] key);
        case (key)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int level_base(input int lvl);
        case (lvl)
            1:       return 1;
            2:       return 3;
            4:       return 5;
            default: return 0;
        endcase
    endfunction

    task automatic go_idle();
        m_state = 0;
        m_points = 0;
        m_streak = 0;
    endtask

    task automatic model_step(input bit start, input bit rstb, input bit rng, input bit to,
                              input bit hit, input int lvl);
        int mult;
        case (m_state)
            0: begin
                m_points = 0;
                m_streak = 0;
                if (start) m_state = 1;
            end
            1: begin
                if (rstb) go_idle();
                else if (rng) m_state = 2;
            end
            2: begin
                if (rstb) go_idle();
                else if (hit) begin
                    mult = (m_streak < 5) ? 1 : level_base(lvl) + m_streak / 5;
                    m_points = m_points + 10 * mult;
                    if (m_points > 65535) m_points = 65535;
                    if (m_streak < 255) m_streak++;
                    m_state = 3;
                end else if (!to) begin
                    m_streak = 0;
                    m_state = 4;
                end
            end
            default: begin
                if (rstb) go_idle();
                else m_state = 1;
            end
        endcase
    endtask

    task automatic step(input bit start, input bit rstb, input bit rng, input bit to,
                        input logic [17:0] tog, input logic [17:0] led, input logic [3:0] key);
        exp_t e;
        @(negedge clk);
        ifc.start_button_pressed = start;
        ifc.reset_button_pressed = rstb;
        ifc.rng_ready            = rng;
        ifc.timeout              = to;
        ifc.toggle_switches      = tog;
        ifc.led_number           = led;
        ifc.key_switches         = key;
        model_step(start, rstb, rng, to, (tog & led) != 18'd0, decode_level(key));
        step_no++;
        e.id     = step_no;
        e.state  = m_state;
        e.ready  = (m_state == 1) ? 1 : 0;
        e.ledx   = (m_state == 2) ? 1 : 0;
        e.points = m_points;
        e.level  = decode_level(key);
        exp_q.push_back(e);
    endtask

    function automatic logic [17:0] rand_led();
        logic [17:0] one;
        one = 18'd1;
        return one << $urandom_range(0, 17);
    endfunction

    // Monitor: one expected record per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn %0d state=%0d ready=%0b ledx=%0b tstart=%0b points=%0d level=%0d",
                         e.id, dut.current_state, ifc.ready_for_mole, ifc.ledx,
                         ifc.timeout_start, ifc.points, ifc.level_select);
                check("state",  e.id, 32'(dut.current_state), 32'(e.state));
                check("ready",  e.id, 32'(ifc.ready_for_mole), 32'(e.ready));
                check("ledx",   e.id, 32'(ifc.ledx), 32'(e.ledx));
                check("tstart", e.id, 32'(ifc.timeout_start), 32'(e.ledx));
                check("points", e.id, 32'(ifc.points), 32'(e.points));
                check("level",  e.id, 32'(ifc.level_select), 32'(e.level));
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d records left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // n hits in a row from idle; optionally checks the running total after every hit.
    task automatic hit_run(input logic [3:0] key, input int n, input bit chk_tbl);
        int mult_tbl[11];
        int cum;
        logic [17:0] led;
        mult_tbl = '{1, 1, 1, 1, 1, 4, 4, 4, 4, 4, 5};
        cum = 0;
        step(0, 1, 0, 1, 18'd0, 18'd0, key);
        step(1, 0, 0, 1, 18'd0, 18'd0, key);
        for (int i = 0; i < n; i++) begin
            led = rand_led();
            step(0, 0, 1, 1, 18'd0, led, key);
            step(0, 0, 0, 1, led, led, key);
            if (chk_tbl && i < 11) begin
                @(posedge clk);
                #2;
                cum = cum + 10 * mult_tbl[i];
                check("mult_seq", step_no, 32'(ifc.points), 32'(cum));
            end
            step(0, 0, 0, 1, 18'd0, led, key);
        end
        drain();
    endtask

    initial begin
        logic [3:0] lvl_keys[6];
        logic [3:0] run_keys[4];
        int         run_pts[4];
        logic [17:0] led;
        logic [17:0] tog;
        logic [3:0]  key;
        int          r;

        lvl_keys = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0011};
        run_keys = '{4'b0011, 4'b0010, 4'b0100, 4'b1000};
        run_pts  = '{120, 180, 300, 420};

        ifc.start_button_pressed = 1'b0;
        ifc.reset_button_pressed = 1'b0;
        ifc.rng_ready            = 1'b0;
        ifc.timeout              = 1'b1;
        ifc.toggle_switches      = '0;
        ifc.led_number           = '0;
        ifc.key_switches         = 4'b0001;

        repeat (2) @(negedge clk);
        check("rst_state",  0, 32'(dut.current_state), 32'd0);
        check("rst_points", 0, 32'(ifc.points), 32'd0);
        check("rst_ready",  0, 32'(ifc.ready_for_mole), 32'd0);
        check("rst_ledx",   0, 32'(ifc.ledx), 32'd0);
        rst_n = 1'b1;

        repeat (3) step(0, 0, 0, 1, 18'd0, 18'd0, 4'b0001);
        step(1, 0, 0, 1, 18'd0, 18'd0, 4'b0001);
        foreach (lvl_keys[i]) step(0, 0, 0, 1, 18'd0, 18'd0, lvl_keys[i]);

        led = 18'd1 << 5;
        step(0, 0, 1, 1, 18'd0, led, 4'b0001);
        step(0, 0, 0, 1, led, led, 4'b0001);
        step(0, 0, 0, 1, 18'd0, led, 4'b0001);
        step(0, 0, 1, 1, 18'd0, led, 4'b0001);
        step(0, 0, 0, 0, 18'd0, led, 4'b0001);
        step(0, 0, 0, 1, 18'd0, led, 4'b0001);
        step(0, 0, 1, 1, 18'd0, led, 4'b0001);
        step(0, 1, 0, 1, 18'd0, led, 4'b0001);
        step(0, 0, 0, 1, 18'd0, led, 4'b0001);
        drain();

        for (int k = 0; k < 4; k++) begin
            hit_run(run_keys[k], 11, run_keys[k] == 4'b0100);
            check("run_points", step_no, 32'(ifc.points), 32'(run_pts[k]));
        end

        // Hit and expired window in the same cycle.
        step(0, 1, 0, 1, 18'd0, 18'd0, 4'b0001);
        step(1, 0, 0, 1, 18'd0, 18'd0, 4'b0001);
        led = 18'd1 << 17;
        step(0, 0, 1, 1, 18'd0, led, 4'b0001);
        step(0, 0, 0, 0, led, led, 4'b0001);
        drain();
        check("hit_vs_to_state",  step_no, 32'(dut.current_state), 32'd3);
        check("hit_vs_to_points", step_no, 32'(ifc.points), 32'd10);

        // Long streak to reach the score ceiling and the streak ceiling.
        hit_run(4'b1000, 300, 1'b0);
        check("sat_points", step_no, 32'(ifc.points), 32'd65535);

        for (int i = 0; i < 600; i++) begin
            led = rand_led();
            r = $urandom_range(0, 2);
            tog = (r == 0) ? led : (r == 1) ? 18'd0 : 18'($urandom);
            r = $urandom_range(0, 6);
            key = (r < 6) ? lvl_keys[r] : 4'($urandom);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0, tog, led, key);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
